rlwe_vmem_serializer: RTL and testbench

Vector-to-scalar data-memory adapter sitting directly downstream of the RLWE load/store stage. It accepts one request at a time on the LSU-side DMEM interface. Vector requests (`SCR1_MEM_WIDTH_VECTOR`) are split into LANE sequential 32-bit word beats on the core's scalar DMEM port. Read beats are reassembled into a `type_vector` response. Scalar byte/halfword/word requests pass through as a single beat.

---
 rtl/rlwe_vmem_serializer_if.sv | 53 +++++
 rtl/rlwe_vmem_serializer.sv | 213 +++++++++++++++++++++
 tb/tb_rlwe_vmem_serializer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rlwe_vmem_serializer_if.sv
// Memory request/response bundle shared by the LSU side (LANE words) and the scalar DMEM side (LANE=1).
// Also supplies default LANE / SCR1_DMEM_AWIDTH and the SCR1 memory command/width/response types.
`ifndef LANE
`define LANE 16
`endif
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

`ifndef RLWE_VMEM_TYPES_SV
`define RLWE_VMEM_TYPES_SV
typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
} type_scr1_mem_cmd_e;

typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE   = 2'b00,
    SCR1_MEM_WIDTH_HWORD  = 2'b01,
    SCR1_MEM_WIDTH_WORD   = 2'b10,
    SCR1_MEM_WIDTH_VECTOR = 2'b11
} type_scr1_mem_width_e;

typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
} type_scr1_mem_resp_e;
`endif

interface rlwe_vmem_serializer_if #(
    parameter int LANE = `LANE,
    parameter int AW   = `SCR1_DMEM_AWIDTH
);
    logic                   req;
    type_scr1_mem_cmd_e     cmd;
    type_scr1_mem_width_e   width;
    logic [AW-1:0]          addr;
    logic [LANE-1:0][31:0]  wdata;
    logic                   req_ack;
    logic [LANE-1:0][31:0]  rdata;
    type_scr1_mem_resp_e    resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );
endinterface

// File: rtl/rlwe_vmem_serializer.sv
// Splits LSU vector requests into LANE word beats on the scalar DMEM port and reassembles read data.
// Define RLWE_VMEM_ERR_ABORT_EN to stop a vector transfer at its first error beat.
module rlwe_vmem_serializer #(
    parameter int LANE = `LANE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rlwe_vmem_serializer_if.slave  lsu,
    rlwe_vmem_serializer_if.master dmem,
    output logic                   vmem_busy
);
    localparam int AW    = `SCR1_DMEM_AWIDTH;
    localparam int IDX_W = (LANE > 1) ? $clog2(LANE) : 1;

`ifdef RLWE_VMEM_ERR_ABORT_EN
    localparam logic ERR_ABORT = 1'b1;
`else
    localparam logic ERR_ABORT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                 state_r;
    state_e                 state_s;
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       idx_s;

    type_scr1_mem_cmd_e     cmd_r;
    type_scr1_mem_width_e   width_r;
    logic                   is_vec_r;
    logic [AW-1:0]          addr_r;
    logic [LANE-1:0][31:0]  wdata_r;
    logic                   err_r;

    logic                   dmem_req_r;
    type_scr1_mem_cmd_e     dmem_cmd_r;
    type_scr1_mem_width_e   dmem_width_r;
    logic [AW-1:0]          dmem_addr_r;
    logic [31:0]            dmem_wdata_r;

    type_scr1_mem_resp_e    lsu_resp_r;
    logic [LANE-1:0][31:0]  rdata_r;
    logic                   busy_r;
    logic                   req_ack_r;

    logic                   accept_s;
    logic                   beat_done_s;
    logic                   beat_err_s;
    logic                   last_beat_s;

    type_scr1_mem_cmd_e     eff_cmd_s;
    type_scr1_mem_width_e   eff_width_s;
    logic                   eff_vec_s;
    logic [AW-1:0]          eff_addr_s;
    logic [LANE-1:0][31:0]  eff_wdata_s;
    logic [AW-1:0]          beat_addr_s;
    logic [31:0]            beat_wdata_s;

    assign accept_s    = (state_r == S_IDLE) && lsu.req;
    assign beat_done_s = (state_r == S_RESP) && (dmem.resp != SCR1_MEM_RESP_NOTRDY);
    assign beat_err_s  = beat_done_s && (dmem.resp == SCR1_MEM_RESP_RDY_ER);
    assign last_beat_s = !is_vec_r || (idx_r == IDX_W'(LANE - 1));

    // Next-state and beat-index sequencing
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            S_IDLE: begin
                if (lsu.req) begin
                    state_s = S_REQ;
                    idx_s   = '0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (dmem.req_ack) begin
                    state_s = S_RESP;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_RESP: begin
                if (beat_done_s) begin
                    if (last_beat_s || (ERR_ABORT && beat_err_s)) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_REQ;
                        idx_s   = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = S_RESP;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                idx_s   = '0;
            end
        endcase
    end

    // Beat parameters; on the accept cycle they come straight from the LSU so beat 0 is ready in REQ
    always_comb begin
        eff_cmd_s    = accept_s ? lsu.cmd   : cmd_r;
        eff_width_s  = accept_s ? lsu.width : width_r;
        eff_vec_s    = accept_s ? (lsu.width == SCR1_MEM_WIDTH_VECTOR) : is_vec_r;
        eff_addr_s   = accept_s ? lsu.addr  : addr_r;
        eff_wdata_s  = accept_s ? lsu.wdata : wdata_r;
        beat_addr_s  = eff_vec_s
                     ? {eff_addr_s[AW-1:2] + {{(AW-2-IDX_W){1'b0}}, idx_s}, 2'b00}
                     : eff_addr_s;
        beat_wdata_s = eff_wdata_s[idx_s];
    end

    // State and beat index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Request capture and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r    <= SCR1_MEM_CMD_RD;
            width_r  <= SCR1_MEM_WIDTH_WORD;
            is_vec_r <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            err_r    <= 1'b0;
        end else if (accept_s) begin
            cmd_r    <= lsu.cmd;
            width_r  <= lsu.width;
            is_vec_r <= (lsu.width == SCR1_MEM_WIDTH_VECTOR);
            addr_r   <= lsu.addr;
            wdata_r  <= lsu.wdata;
            err_r    <= 1'b0;
        end else if (beat_err_s) begin
            err_r    <= 1'b1;
        end
    end

    // Scalar port outputs, loaded whenever the next state is REQ so they stay stable until ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_r   <= 1'b0;
            dmem_cmd_r   <= SCR1_MEM_CMD_RD;
            dmem_width_r <= SCR1_MEM_WIDTH_WORD;
            dmem_addr_r  <= '0;
            dmem_wdata_r <= 32'h0000_0000;
        end else begin
            dmem_req_r <= (state_s == S_REQ);
            if (state_s == S_REQ) begin
                dmem_cmd_r   <= eff_cmd_s;
                dmem_width_r <= eff_vec_s ? SCR1_MEM_WIDTH_WORD : eff_width_s;
                dmem_addr_r  <= beat_addr_s;
                dmem_wdata_r <= beat_wdata_s;
            end
        end
    end

    // LSU-side response, handshake and busy flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_resp_r <= SCR1_MEM_RESP_NOTRDY;
            busy_r     <= 1'b0;
            req_ack_r  <= 1'b1;
        end else begin
            if (state_s == S_DONE) begin
                lsu_resp_r <= (err_r || beat_err_s) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            end else begin
                lsu_resp_r <= SCR1_MEM_RESP_NOTRDY;
            end
            busy_r    <= (state_s != S_IDLE);
            req_ack_r <= (state_s == S_IDLE);
        end
    end

    // Read assembly; the result is held after DONE because the LSU samples it late
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (accept_s && (lsu.cmd == SCR1_MEM_CMD_RD)) begin
            rdata_r <= '0;
        end else if (beat_done_s && (cmd_r == SCR1_MEM_CMD_RD)) begin
            rdata_r[idx_r] <= dmem.rdata[0];
        end
    end

    assign dmem.req      = dmem_req_r;
    assign dmem.cmd      = dmem_cmd_r;
    assign dmem.width    = dmem_width_r;
    assign dmem.addr     = dmem_addr_r;
    assign dmem.wdata[0] = dmem_wdata_r;

    assign lsu.req_ack   = req_ack_r;
    assign lsu.rdata     = rdata_r;
    assign lsu.resp      = lsu_resp_r;
    assign vmem_busy     = busy_r;
endmodule

// File: tb/tb_rlwe_vmem_serializer.sv
// Self-checking bench: table vectors, randomized transfers against a transfer-level model, and reset mid-transfer.
module tb_rlwe_vmem_serializer;
    localparam int LANE = `LANE;
`ifdef RLWE_VMEM_ERR_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif
    localparam int NO_ERR = 999;

    logic clk;
    logic rst_n;
    logic vmem_busy;

    rlwe_vmem_serializer_if #(.LANE(LANE)) lsu_bus ();
    rlwe_vmem_serializer_if #(.LANE(1))    dmem_bus ();

    rlwe_vmem_serializer #(.LANE(LANE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lsu       (lsu_bus),
        .dmem      (dmem_bus),
        .vmem_busy (vmem_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_mis = 0;

    // memory-model configuration, written only by the main process
    int          ack_w [LANE];
    int          resp_w[LANE];
    int          err_beat;
    logic [31:0] rbase;
    bit          slave_en;
    bit          stale;
    int          slave_gen;

    // memory-model state and beat log, written only by the memory process
    int                   s_phase, s_beat, s_wcnt, s_nack, s_seen_gen;
    logic [31:0]          log_addr [64];
    logic [31:0]          log_wdata[64];
    type_scr1_mem_cmd_e   log_cmd  [64];
    type_scr1_mem_width_e log_width[64];

    logic [LANE-1:0][31:0] exp_rd;

    function automatic int wait_of(input int arr[LANE], input int b);
        return (b < LANE) ? arr[b] : 0;
    endfunction

    // Scalar memory: acks after ack_w[beat] cycles, responds after resp_w[beat] further cycles
    initial begin
        s_phase = 0; s_beat = 0; s_wcnt = 0; s_nack = 0; s_seen_gen = 0;
        dmem_bus.req_ack = 1'b0;
        dmem_bus.resp    = SCR1_MEM_RESP_NOTRDY;
        dmem_bus.rdata   = '0;
        forever begin
            @(negedge clk);
            if (s_seen_gen != slave_gen) begin
                s_seen_gen = slave_gen;
                s_phase = 0; s_beat = 0; s_wcnt = 0; s_nack = 0;
            end
            dmem_bus.req_ack = 1'b0;
            dmem_bus.resp    = SCR1_MEM_RESP_NOTRDY;
            if (stale) begin
                dmem_bus.resp = SCR1_MEM_RESP_RDY_OK;
            end else if (slave_en && rst_n) begin
                if (s_phase == 0) begin
                    if (dmem_bus.req) begin
                        if (s_wcnt < wait_of(ack_w, s_beat)) begin
                            s_wcnt++;
                        end else begin
                            dmem_bus.req_ack = 1'b1;
                            if (s_nack < 64) begin
                                log_addr[s_nack]  = dmem_bus.addr;
                                log_wdata[s_nack] = dmem_bus.wdata[0];
                                log_cmd[s_nack]   = dmem_bus.cmd;
                                log_width[s_nack] = dmem_bus.width;
                            end
                            s_nack++;
                            s_wcnt  = 0;
                            s_phase = 1;
                        end
                    end
                end else begin
                    if (s_wcnt < wait_of(resp_w, s_beat)) begin
                        s_wcnt++;
                    end else begin
                        dmem_bus.resp = (s_beat == err_beat) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                        dmem_bus.rdata[0] = rbase + 32'(s_beat);
                        s_beat++;
                        s_wcnt  = 0;
                        s_phase = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rdata(input string tag);
        for (int i = 0; i < LANE; i++) begin
            check($sformatf("%s.rdata[%0d]", tag, i), 64'(lsu_bus.rdata[i]), 64'(exp_rd[i]));
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < LANE; i++) begin
            ack_w[i]  = 0;
            resp_w[i] = 0;
        end
        err_beat = NO_ERR;
    endtask

    function automatic int model_beats(input type_scr1_mem_width_e wid);
        int n;
        n = (wid == SCR1_MEM_WIDTH_VECTOR) ? LANE : 1;
        if (ABORT && err_beat < n) n = err_beat + 1;
        return n;
    endfunction

    // Runs from just after the accepting edge to one cycle past DONE
    task automatic finish_txn(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e wid,
                              input logic [31:0] addr, input logic [LANE-1:0][31:0] wd,
                              input int exp_cycle, input type_scr1_mem_resp_e exp_resp, input string tag);
        int cyc;
        bit got;
        int n;
        bit vec;
        logic [31:0] ea;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clk); #1;
            cyc++;
            lsu_bus.req = 1'b0;
            if (lsu_bus.resp != SCR1_MEM_RESP_NOTRDY) got = 1'b1;
        end
        check({tag, ".resp_seen"}, 64'(got), 64'd1);
        check({tag, ".cycle"}, 64'(cyc), 64'(exp_cycle));
        check({tag, ".resp"}, 64'(lsu_bus.resp), 64'(exp_resp));

        vec = (wid == SCR1_MEM_WIDTH_VECTOR);
        n   = model_beats(wid);
        check({tag, ".beats"}, 64'(s_nack), 64'(n));
        for (int i = 0; i < n && i < s_nack; i++) begin
            ea = vec ? ((addr & 32'hFFFF_FFFC) + 32'(4 * i)) : addr;
            check($sformatf("%s.addr%0d", tag, i), 64'(log_addr[i]), 64'(ea));
            check($sformatf("%s.cmdw%0d", tag, i), 64'({log_cmd[i], log_width[i]}),
                  64'({cmd, vec ? SCR1_MEM_WIDTH_WORD : wid}));
            if (cmd == SCR1_MEM_CMD_WR)
                check($sformatf("%s.wdata%0d", tag, i), 64'(log_wdata[i]), 64'(wd[i]));
        end
        if (cmd == SCR1_MEM_CMD_RD) begin
            exp_rd = '0;
            for (int i = 0; i < n; i++) exp_rd[i] = rbase + 32'(i);
        end
        check_rdata(tag);

        @(negedge clk); #1;
        check({tag, ".resp_one_cycle"}, 64'(lsu_bus.resp), 64'(SCR1_MEM_RESP_NOTRDY));
        check({tag, ".idle"}, 64'({lsu_bus.req_ack, vmem_busy}), 64'({1'b1, 1'b0}));
        check_rdata({tag, ".held"});
    endtask

    task automatic run_txn(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e wid,
                           input logic [31:0] addr, input logic [LANE-1:0][31:0] wd,
                           input int exp_cycle, input type_scr1_mem_resp_e exp_resp, input string tag);
        slave_gen++;
        @(negedge clk); #1;
        check({tag, ".req_ack"}, 64'(lsu_bus.req_ack), 64'd1);
        lsu_bus.req   = 1'b1;
        lsu_bus.cmd   = cmd;
        lsu_bus.width = wid;
        lsu_bus.addr  = addr;
        lsu_bus.wdata = wd;
        @(posedge clk);
        finish_txn(cmd, wid, addr, wd, exp_cycle, exp_resp, tag);
    endtask

    typedef struct {
        type_scr1_mem_cmd_e   cmd;
        type_scr1_mem_width_e wid;
        logic [31:0]          addr;
        logic [31:0]          rb;
        logic [31:0]          wbase;
        logic [31:0]          wmul;
        int                   ack_beat;
        int                   ack_wait;
        int                   resp_beat;
        int                   resp_wait;
        int                   err;
        int                   exp_cycle;
        type_scr1_mem_resp_e  exp_resp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LANE-1:0][31:0] wd;
        type_scr1_mem_cmd_e    rcmd;
        type_scr1_mem_width_e  rwid;
        logic [31:0]           raddr;
        int                    r, n, sum, found;

        tbl[0] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h0000_0100, 32'h0000_A000, 32'h0, 32'h0,
                   -1, 0, -1, 0, NO_ERR, 33, SCR1_MEM_RESP_RDY_OK};
        tbl[1] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h0000_0200, 32'h0, 32'h0, 32'h1111_1111,
                   5, 2, -1, 0, NO_ERR, 35, SCR1_MEM_RESP_RDY_OK};
        tbl[2] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h0000_0203, 32'h0000_00FF, 32'h0, 32'h0,
                   -1, 0, -1, 0, NO_ERR, 3, SCR1_MEM_RESP_RDY_OK};
        tbl[3] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h0000_0300, 32'h0000_C000, 32'h0, 32'h0,
                   -1, 0, -1, 0, 3, ABORT ? 9 : 33, SCR1_MEM_RESP_RDY_ER};
        tbl[4] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'hFFFF_FFF0, 32'h0000_D000, 32'h0, 32'h0,
                   -1, 0, -1, 0, NO_ERR, 33, SCR1_MEM_RESP_RDY_OK};
        tbl[5] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0000_0404, 32'h1234_5678, 32'h0, 32'h0,
                   -1, 0, 0, 3, NO_ERR, 6, SCR1_MEM_RESP_RDY_OK};
        tbl[6] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h0000_1002, 32'h0, 32'hCAFE_1234, 32'h0,
                   -1, 0, -1, 0, NO_ERR, 3, SCR1_MEM_RESP_RDY_OK};
        tbl[7] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h0000_0503, 32'h0000_E000, 32'h0, 32'h0,
                   -1, 0, 15, 1, NO_ERR, 34, SCR1_MEM_RESP_RDY_OK};

        rst_n = 1'b0;
        slave_en = 1'b0;
        stale = 1'b0;
        slave_gen = 0;
        rbase = 32'h0;
        clear_cfg();
        lsu_bus.req = 1'b0;
        lsu_bus.cmd = SCR1_MEM_CMD_RD;
        lsu_bus.width = SCR1_MEM_WIDTH_WORD;
        lsu_bus.addr = 32'h0;
        lsu_bus.wdata = '0;
        exp_rd = '0;

        repeat (3) @(negedge clk);
        #1;
        check("reset.dmem_req", 64'(dmem_bus.req), 64'd0);
        check("reset.dmem_cmdw", 64'({dmem_bus.cmd, dmem_bus.width}), 64'({SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD}));
        check("reset.dmem_addr", 64'(dmem_bus.addr), 64'd0);
        check("reset.lsu_resp", 64'(lsu_bus.resp), 64'(SCR1_MEM_RESP_NOTRDY));
        check("reset.flags", 64'({lsu_bus.req_ack, vmem_busy}), 64'({1'b1, 1'b0}));
        check_rdata("reset");
        rst_n = 1'b1;
        slave_en = 1'b1;

        for (int t = 0; t < 8; t++) begin
            clear_cfg();
            if (tbl[t].ack_beat >= 0)  ack_w[tbl[t].ack_beat]   = tbl[t].ack_wait;
            if (tbl[t].resp_beat >= 0) resp_w[tbl[t].resp_beat] = tbl[t].resp_wait;
            err_beat = tbl[t].err;
            rbase = tbl[t].rb;
            for (int i = 0; i < LANE; i++) wd[i] = tbl[t].wbase + tbl[t].wmul * 32'(i);
            run_txn(tbl[t].cmd, tbl[t].wid, tbl[t].addr, wd, tbl[t].exp_cycle, tbl[t].exp_resp,
                    $sformatf("tbl%0d", t));
        end

        for (int k = 0; k < 30; k++) begin
            clear_cfg();
            rcmd = ($urandom_range(0, 1) == 1) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
            r = $urandom_range(0, 5);
            rwid = (r >= 3) ? SCR1_MEM_WIDTH_VECTOR : type_scr1_mem_width_e'(2'(r));
            raddr = $urandom;
            if (k % 5 == 0) raddr = 32'hFFFF_FFC0 | ($urandom & 32'h0000_003F);
            for (int i = 0; i < LANE; i++) begin
                wd[i] = $urandom;
                ack_w[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                resp_w[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            err_beat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, LANE - 1) : NO_ERR;
            rbase = $urandom;
            n = model_beats(rwid);
            sum = 0;
            for (int i = 0; i < n; i++) sum += ack_w[i] + resp_w[i];
            run_txn(rcmd, rwid, raddr, wd, 2 * n + 1 + sum,
                    (err_beat < n) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK,
                    $sformatf("rnd%0d", k));
        end

        // reset during RESP of beat 7, with a stale RDY_OK left on the bus
        clear_cfg();
        rbase = 32'h0000_B000;
        slave_gen++;
        @(negedge clk); #1;
        lsu_bus.req = 1'b1;
        lsu_bus.cmd = SCR1_MEM_CMD_RD;
        lsu_bus.width = SCR1_MEM_WIDTH_VECTOR;
        lsu_bus.addr = 32'h0000_0600;
        @(posedge clk);
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk); #1;
            lsu_bus.req = 1'b0;
            if (s_beat == 7 && s_phase == 1) found = 1;
        end
        check("rst.reached_beat7", 64'(found), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        slave_en = 1'b0;
        stale = 1'b1;
        #1;
        exp_rd = '0;
        check("rst.dmem_req", 64'(dmem_bus.req), 64'd0);
        check("rst.dmem_cmdw", 64'({dmem_bus.cmd, dmem_bus.width}), 64'({SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD}));
        check("rst.dmem_addr", 64'(dmem_bus.addr), 64'd0);
        check("rst.dmem_wdata", 64'(dmem_bus.wdata[0]), 64'd0);
        check("rst.lsu_resp", 64'(lsu_bus.resp), 64'(SCR1_MEM_RESP_NOTRDY));
        check("rst.flags", 64'({lsu_bus.req_ack, vmem_busy}), 64'({1'b1, 1'b0}));
        check_rdata("rst");
        repeat (2) @(negedge clk);
        #1;
        check("rst.no_resp_in_reset", 64'(lsu_bus.resp), 64'(SCR1_MEM_RESP_NOTRDY));
        rst_n = 1'b1;
        clear_cfg();
        rbase = 32'h0000_B700;
        slave_gen++;
        slave_en = 1'b1;
        stale = 1'b0;
        check("rst.req_ack_after", 64'(lsu_bus.req_ack), 64'd1);
        lsu_bus.req = 1'b1;
        lsu_bus.cmd = SCR1_MEM_CMD_RD;
        lsu_bus.width = SCR1_MEM_WIDTH_WORD;
        lsu_bus.addr = 32'h0000_0700;
        lsu_bus.wdata = '0;
        @(posedge clk);
        finish_txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0000_0700, '0, 3,
                   SCR1_MEM_RESP_RDY_OK, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
